wave_sequencer: RTL and testbench

Playlist controller that drives the waveform generator's selection and frequency inputs. It holds a small table of segments; each segment sets a waveform type, a frequency control word, a pulse duty word and a duration. Once started, it steps through the table, optionally looping. It sits between the host configuration registers and the generator's `wave_sel`, `freq_ctrl` and `pulse_duty_cycle` inputs, so timed multi-waveform patterns play without host involvement.

---
 rtl/wave_seq_pkg.sv | 26 ++
 rtl/wave_seq_table.sv | 36 +++
 rtl/wave_sequencer.sv | 176 +++++++++++++++++
 tb/tb_wave_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the wave_sequencer playlist controller.
package wave_seq_pkg;

  // Widest duration any instance may use; instances truncate to their DUR_W.
  localparam int WAVE_SEQ_DUR_MAX_W = 32;

  localparam logic [1:0] WAVE_NCO   = 2'b00;
  localparam logic [1:0] WAVE_CHIRP = 2'b01;
  localparam logic [1:0] WAVE_SAW   = 2'b10;
  localparam logic [1:0] WAVE_PULSE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } wave_seq_state_t;

  typedef struct packed {
    logic [1:0]                    wave_sel;
    logic [31:0]                   freq;
    logic [31:0]                   duty;
    logic [WAVE_SEQ_DUR_MAX_W-1:0] dur;
    logic                          last;
  } wave_seq_entry_t;

endpackage

// File: rtl/wave_seq_table.sv
// Segment register file: synchronous write, asynchronous read, async clear.
module wave_seq_table
  import wave_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  wave_seq_entry_t wdata,
  input  logic [AW-1:0]   raddr,
  output wave_seq_entry_t rdata
);

  wave_seq_entry_t mem_q [DEPTH];
  wave_seq_entry_t mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Read sees pre-write contents on a same-edge write.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/wave_sequencer.sv
// Playlist controller stepping through segment entries to drive the generator.
// Optional WAVE_SEQ_LOOP_CNT_EN adds loop_cnt to bound the number of passes.
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DUR_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [1:0]               cfg_wave_sel,
  input  logic [31:0]              cfg_freq,
  input  logic [31:0]              cfg_duty,
  input  logic [DUR_W-1:0]         cfg_dur,
  input  logic                     cfg_last,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
`ifdef WAVE_SEQ_LOOP_CNT_EN
  input  logic [7:0]               loop_cnt,
`endif
  output logic [1:0]               gen_wave_sel,
  output logic [31:0]              gen_freq_ctrl,
  output logic [31:0]              gen_duty,
  output logic [$clog2(DEPTH)-1:0] seg_idx,
  output logic                     seg_start,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  wave_seq_state_t state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d, seg_idx_q, seg_idx_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [1:0]       wave_q, wave_d;
  logic [31:0]      freq_q, freq_d, duty_q, duty_d;
  logic             last_q, last_d;
  logic             seg_start_q, seg_start_d, busy_q, busy_d, done_q, done_d;
  logic             loop_more;
  wave_seq_entry_t  wr_entry, rd_entry;

  assign wr_entry = '{wave_sel: cfg_wave_sel, freq: cfg_freq, duty: cfg_duty,
                      dur: WAVE_SEQ_DUR_MAX_W'(cfg_dur), last: cfg_last};

  wave_seq_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (wr_entry),
    .raddr (idx_q),
    .rdata (rd_entry)
  );

`ifdef WAVE_SEQ_LOOP_CNT_EN
  logic [7:0] pass_q, pass_d;
  assign loop_more = loop_en && ((loop_cnt == 8'd0) || (pass_q != loop_cnt));
`else
  assign loop_more = loop_en;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seg_idx_d   = seg_idx_q;
    cnt_d       = cnt_q;
    wave_d      = wave_q;
    freq_d      = freq_q;
    duty_d      = duty_q;
    last_d      = last_q;
    seg_start_d = 1'b0;
    done_d      = 1'b0;
`ifdef WAVE_SEQ_LOOP_CNT_EN
    pass_d      = pass_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
          idx_d   = '0;
`ifdef WAVE_SEQ_LOOP_CNT_EN
          pass_d  = '0;
`endif
        end
      end
      LOAD: begin
        state_d     = PLAY;
        wave_d      = rd_entry.wave_sel;
        freq_d      = rd_entry.freq;
        duty_d      = rd_entry.duty;
        seg_idx_d   = idx_q;
        // A zero duration still plays one cycle.
        cnt_d       = (rd_entry.dur == '0) ? '0 :
                      DUR_W'(rd_entry.dur - WAVE_SEQ_DUR_MAX_W'(1));
        last_d      = rd_entry.last || (idx_q == AW'(DEPTH - 1));
        seg_start_d = 1'b1;
      end
      PLAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DUR_W'(1);
        end else if (!last_q) begin
          idx_d   = idx_q + AW'(1);
          state_d = LOAD;
        end else if (loop_more) begin
          idx_d   = '0;
          state_d = LOAD;
`ifdef WAVE_SEQ_LOOP_CNT_EN
          pass_d  = pass_q + 8'd1;
`endif
        end else begin
          state_d = IDLE;
          freq_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything: stall the accumulators, hold the rest.
    if (stop) begin
      state_d     = IDLE;
      freq_d      = '0;
      wave_d      = wave_q;
      duty_d      = duty_q;
      seg_idx_d   = seg_idx_q;
      seg_start_d = 1'b0;
      done_d      = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      seg_idx_q   <= '0;
      cnt_q       <= '0;
      wave_q      <= '0;
      freq_q      <= '0;
      duty_q      <= '0;
      last_q      <= 1'b0;
      seg_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef WAVE_SEQ_LOOP_CNT_EN
      pass_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seg_idx_q   <= seg_idx_d;
      cnt_q       <= cnt_d;
      wave_q      <= wave_d;
      freq_q      <= freq_d;
      duty_q      <= duty_d;
      last_q      <= last_d;
      seg_start_q <= seg_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef WAVE_SEQ_LOOP_CNT_EN
      pass_q      <= pass_d;
`endif
    end
  end

  assign gen_wave_sel  = wave_q;
  assign gen_freq_ctrl = freq_q;
  assign gen_duty      = duty_q;
  assign seg_idx       = seg_idx_q;
  assign seg_start     = seg_start_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer; covers WAVE_SEQ_LOOP_CNT_EN when defined.
module tb_wave_sequencer;
  import wave_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cfg_we, cfg_last, start, stop, loop_en;
  logic [2:0]  cfg_addr;
  logic [1:0]  cfg_wave_sel;
  logic [31:0] cfg_freq, cfg_duty;
  logic [23:0] cfg_dur;
  logic [1:0]  gen_wave_sel;
  logic [31:0] gen_freq_ctrl, gen_duty;
  logic [2:0]  seg_idx;
  logic        seg_start, busy, done;
`ifdef WAVE_SEQ_LOOP_CNT_EN
  logic [7:0]  loop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_b [1:9];

  localparam logic [31:0] F1 = 32'h0100_0000;
  localparam logic [31:0] F2 = 32'h0200_0000;

  wave_sequencer #(.DEPTH(8), .DUR_W(24)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wave_sel(cfg_wave_sel), .cfg_freq(cfg_freq), .cfg_duty(cfg_duty),
    .cfg_dur(cfg_dur), .cfg_last(cfg_last), .start(start), .stop(stop),
    .loop_en(loop_en),
`ifdef WAVE_SEQ_LOOP_CNT_EN
    .loop_cnt(loop_cnt),
`endif
    .gen_wave_sel(gen_wave_sel), .gen_freq_ctrl(gen_freq_ctrl),
    .gen_duty(gen_duty), .seg_idx(seg_idx), .seg_start(seg_start),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] ov(input logic [1:0] w, input logic [31:0] f,
                                     input logic ss, input logic b, input logic d,
                                     input logic [2:0] ix);
    return {w, f, ss, b, d, ix};
  endfunction

  function automatic logic [39:0] obs();
    return {gen_wave_sel, gen_freq_ctrl, seg_start, busy, done, seg_idx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input int c, input logic [39:0] e);
    chk($sformatf("%s c%0d", tag, c), 64'(obs()), 64'(e));
    step();
  endtask

  task automatic wr(input int a, input logic [1:0] w, input logic [31:0] f,
                    input logic [31:0] d, input logic [23:0] du, input logic l);
    cfg_addr = 3'(a); cfg_wave_sel = w; cfg_freq = f; cfg_duty = d;
    cfg_dur = du; cfg_last = l; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 0; cfg_last = 0; start = 0; stop = 0; loop_en = 0;
    cfg_addr = 0; cfg_wave_sel = 0; cfg_freq = 0; cfg_duty = 0; cfg_dur = 0;
`ifdef WAVE_SEQ_LOOP_CNT_EN
    loop_cnt = 0;
`endif
    exp_b[1] = ov(WAVE_NCO, 0, 0, 1, 0, 0);
    exp_b[2] = ov(WAVE_SAW, F1, 1, 1, 0, 0);
    exp_b[3] = ov(WAVE_SAW, F1, 0, 1, 0, 0);
    exp_b[4] = ov(WAVE_SAW, F1, 0, 1, 0, 0);
    exp_b[5] = ov(WAVE_SAW, F1, 0, 1, 0, 0);
    exp_b[6] = ov(WAVE_NCO, F2, 1, 1, 0, 1);
    exp_b[7] = ov(WAVE_NCO, F2, 0, 1, 0, 1);
    exp_b[8] = ov(WAVE_NCO, 0, 0, 0, 1, 1);
    exp_b[9] = ov(WAVE_NCO, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("reset_state", {gen_duty, obs()}, 64'd0);

    // Basic playback
    wr(0, WAVE_SAW, F1, 32'd0, 24'd3, 1'b0);
    wr(1, WAVE_NCO, F2, 32'd0, 24'd2, 1'b1);
    go();
    for (int c = 1; c <= 9; c++) expect_cyc("basic", c, exp_b[c]);

    // Loop: entry 0 reloads after entry 1, no done
    loop_en = 1'b1;
    go();
    expect_cyc("loop", 1, ov(WAVE_NCO, 0, 0, 1, 0, 1));
    for (int c = 2; c <= 7; c++) expect_cyc("loop", c, exp_b[c]);
    expect_cyc("loop", 8, ov(WAVE_NCO, F2, 0, 1, 0, 1));
    chk("loop c9", 64'(obs()), 64'(ov(WAVE_SAW, F1, 1, 1, 0, 0)));
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
    expect_cyc("loop_stop", 10, ov(WAVE_SAW, 0, 0, 0, 0, 0));

    // Stop beats start from IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    expect_cyc("stop_prio", 1, ov(WAVE_SAW, 0, 0, 0, 0, 0));
    expect_cyc("stop_prio", 2, ov(WAVE_SAW, 0, 0, 0, 0, 0));

    // Stop in cycle 4 of playback
    go();
    expect_cyc("stop_mid", 1, ov(WAVE_SAW, 0, 0, 1, 0, 0));
    expect_cyc("stop_mid", 2, exp_b[2]);
    expect_cyc("stop_mid", 3, exp_b[3]);
    chk("stop_mid c4", 64'(obs()), 64'(exp_b[4]));
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_cyc("stop_mid", 5, ov(WAVE_SAW, 0, 0, 0, 0, 0));
    expect_cyc("stop_mid", 6, ov(WAVE_SAW, 0, 0, 0, 0, 0));

    // Zero duration plays a single cycle
    wr(0, WAVE_PULSE, 32'd3, 32'h55, 24'd0, 1'b1);
    go();
    expect_cyc("dur0", 1, ov(WAVE_SAW, 0, 0, 1, 0, 0));
    chk("dur0 duty", 64'(gen_duty), 64'h55);
    expect_cyc("dur0", 2, ov(WAVE_PULSE, 3, 1, 1, 0, 0));
    expect_cyc("dur0", 3, ov(WAVE_PULSE, 0, 0, 0, 1, 0));

    // No last flag: entry 7 ends the list
    for (int i = 0; i < 8; i++) wr(i, 2'(i % 4), 32'(i + 1), 32'd0, 24'd1, 1'b0);
    go();
    expect_cyc("nolast", 1, ov(WAVE_PULSE, 0, 0, 1, 0, 0));
    for (int c = 2; c <= 16; c++) begin
      if (c % 2 == 0)
        expect_cyc("nolast", c, ov(2'((c - 2) / 2 % 4), 32'((c - 2) / 2 + 1), 1, 1, 0, 3'((c - 2) / 2)));
      else
        expect_cyc("nolast", c, ov(2'((c - 3) / 2 % 4), 32'((c - 3) / 2 + 1), 0, 1, 0, 3'((c - 3) / 2)));
    end
    expect_cyc("nolast", 17, ov(WAVE_PULSE, 0, 0, 0, 1, 7));

    // Writing the playing entry leaves live outputs alone until next LOAD
    wr(0, WAVE_SAW, 32'hA, 32'd0, 24'd4, 1'b1);
    loop_en = 1'b1;
    go();
    expect_cyc("livewr", 1, ov(WAVE_PULSE, 0, 0, 1, 0, 7));
    expect_cyc("livewr", 2, ov(WAVE_SAW, 32'hA, 1, 1, 0, 0));
    chk("livewr c3", 64'(obs()), 64'(ov(WAVE_SAW, 32'hA, 0, 1, 0, 0)));
    wr(0, WAVE_PULSE, 32'hB, 32'd0, 24'd1, 1'b1);
    expect_cyc("livewr", 4, ov(WAVE_SAW, 32'hA, 0, 1, 0, 0));
    expect_cyc("livewr", 5, ov(WAVE_SAW, 32'hA, 0, 1, 0, 0));
    expect_cyc("livewr", 6, ov(WAVE_SAW, 32'hA, 0, 1, 0, 0));
    chk("livewr c7", 64'(obs()), 64'(ov(WAVE_PULSE, 32'hB, 1, 1, 0, 0)));
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
    expect_cyc("livewr", 8, ov(WAVE_PULSE, 0, 0, 0, 0, 0));

    // Async reset mid-PLAY, then a cleared table plays 8 one-cycle entries
    wr(0, WAVE_SAW, 32'h11, 32'h22, 24'd5, 1'b1);
    go();
    step();
    step();
    chk("pre_arst busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst outputs", {gen_duty, obs()}, 64'd0);
    #1 reset = 1'b0;
    step();
    go();
    expect_cyc("cleared", 1, ov(WAVE_NCO, 0, 0, 1, 0, 0));
    for (int i = 0; i < 8; i++) begin
      expect_cyc("cleared", 2 + 2 * i, ov(WAVE_NCO, 0, 1, 1, 0, 3'(i)));
      if (i < 7) expect_cyc("cleared", 3 + 2 * i, ov(WAVE_NCO, 0, 0, 1, 0, 3'(i)));
    end
    expect_cyc("cleared", 17, ov(WAVE_NCO, 0, 0, 0, 1, 7));

`ifdef WAVE_SEQ_LOOP_CNT_EN
    // loop_cnt=2: three 5-cycle segments, then done
    wr(0, WAVE_SAW, 32'h7, 32'd0, 24'd4, 1'b1);
    loop_en = 1'b1;
    loop_cnt = 8'd2;
    go();
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("loopcnt c%0d", c), 64'({seg_start, busy, done}),
          64'({(c == 2 || c == 7 || c == 12), (c <= 15), (c == 16)}));
      step();
    end
    loop_en = 1'b0;
    loop_cnt = 8'd0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
